// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage.
// Multiply is a registered product; divide is a restoring divider.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;

    logic             accept;
    logic             in_sgn, q_sgn;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted, diff;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign accept = in_valid & in_ready & ~flush;
    assign in_sgn = ~op[0];
    assign q_sgn  = ~op_q[0];

    // Operand magnitudes at accept; DIVU keeps raw operands
    always_comb begin
        a_abs = (in_sgn & srca[WIDTH-1]) ? -srca : srca;
        b_abs = (in_sgn & srcb[WIDTH-1]) ? -srcb : srcb;
    end

    // Restoring step, product and sign fix-up from latched operands
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        ext_a   = {(q_sgn ? {WIDTH{a_q[WIDTH-1]}} : {WIDTH{1'b0}}), a_q};
        ext_b   = {(q_sgn ? {WIDTH{b_q[WIDTH-1]}} : {WIDTH{1'b0}}), b_q};
        prod    = ext_a * ext_b;
        q_fix   = quo_q;
        r_fix   = rem_q;
        if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (q_sgn) begin
            if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) q_fix = -quo_q;
            if (a_q[WIDTH-1])                r_fix = -rem_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // Next-state logic; flush wins in every state
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_d = op[1] ? DIV : MUL;
                MUL:  if (cnt == MUL_LAST) state_d = DONE;
                DIV:  if (cnt == DIV_LAST) state_d = DONE;
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs decode state directly
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Datapath: operand latch, divider iteration, result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (state == state_d && (state == MUL || state == DIV))
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
            if (accept) begin
                op_q  <= op;
                a_q   <= srca;
                b_q   <= srcb;
                rem_q <= '0;
                quo_q <= a_abs;
                dvs_q <= b_abs;
            end
            if (state == DIV && !flush && cnt != DIV_LAST) begin
                if (!diff[WIDTH]) begin
                    rem_q <= diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            out_valid <= (state_d == DONE);
            if (state_d == DONE && state != DONE) begin
                if (op_q[1]) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    {hi, lo} <= prod;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, decoupled
// monitor checking result values and output latency.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = W + 1;

    logic         clk = 0;
    logic         resetn = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [1:0]   op = 0;
    logic [W-1:0] srca = 0;
    logic [W-1:0] srcb = 0;
    logic         flush = 0;
    logic         out_valid;
    logic         out_ready = 1;
    logic [W-1:0] hi, lo;
    logic         busy;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_v = 0;

    muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .srca(srca), .srcb(srcb), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: latency on each rising out_valid, values on handshake
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (out_valid && !prev_v) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got 1 expected 0 at cycle %0d", cyc);
                end else if (cyc != sb[0].due) begin
                    errors++;
                    $display("FAIL latency: got cycle %0d expected %0d", cyc, sb[0].due);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
            end
        end
        prev_v = out_valid;
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input bit push);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1");
        end
        in_valid = 1;
        op = o;
        srca = a;
        srcb = b;
        if (push) begin
            e.hi = ehi;
            e.lo = elo;
            e.due = cyc + 1 + (o[1] ? DIV_LAT : MUL_LAT);
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || !in_ready) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        @(negedge clk);
        resetn = 1;

        issue(2'b00, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1);
        issue(2'b01, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 1);
        issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1);
        issue(2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
        issue(2'b11, 32'hFFFFFFF9, 32'h2, 32'h1, 32'h7FFFFFFC, 1);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1);
        issue(2'b11, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 1);
        issue(2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1);
        issue(2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
        drain();

        // Flush a DIV at iteration 10; its result must never appear
        issue(2'b10, 32'h64, 32'h7, 32'h0, 32'h0, 0);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_in_ready", W'(in_ready), W'(1));
        chk("flush_busy", W'(busy), W'(0));
        chk("flush_hold_hi", hi, 32'hFFFFFFFB);
        chk("flush_hold_lo", lo, 32'hFFFFFFFF);
        repeat (40) @(negedge clk);

        // Back-pressure: hold result for 5 cycles, then release
        out_ready = 0;
        issue(2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_hi", hi, 32'h0);
            chk("bp_lo", lo, 32'hC);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        chk("bp_release_out_valid", W'(out_valid), W'(0));

        // Async reset in the middle of a multiply
        issue(2'b00, 32'h1234, 32'h5678, 32'h0, 32'h0, 0);
        chk("mid_mul_busy", W'(busy), W'(1));
        #2;
        resetn = 0;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_hi", hi, '0);
        chk("arst_lo", lo, '0);
        @(negedge clk);
        resetn = 1;
        repeat (6) @(negedge clk);
        chk("post_rst_out_valid", W'(out_valid), W'(0));

        issue(2'b01, 32'h6, 32'h7, 32'h0, 32'h2A, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the execute stage, the successor to the single-cycle combinational MULT/DIV path inside the functional unit. It accepts one MULT, MULTU, DIV or DIVU operation through a valid/ready handshake and computes the result over several cycles. The multiply latency is configurable; the divider is a one-bit-per-cycle restoring divider. It returns the HI/LO pair through a second valid/ready handshake, and an exception/branch flush can abort the operation at any time. Commit logic uses `busy` to stall HI/LO readers.

## Interface
- `WIDTH`, default 32: operand width; `hi` and `lo` are each `WIDTH` bits wide.
- `MUL_CYCLES`, default 2: cycles from acceptance to `out_valid` for multiplies; legal range 1..4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation present.
- `in_ready`  out  1  unit can accept; equal to `state==IDLE`.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srca`  in  WIDTH  multiplicand or dividend (rs).
- `srcb`  in  WIDTH  multiplier or divisor (rt).
- `flush`  in  1  abort the current operation and discard its result.
- `out_valid`  out  1  `hi`/`lo` hold a valid result.
- `out_ready`  in  1  consumer takes the result.
- `hi`  out  WIDTH  upper product half, or remainder.
- `lo`  out  WIDTH  lower product half, or quotient.
- `busy`  out  1  set in any state other than IDLE.

## Operation
- **States:** IDLE, MUL, DIV, DONE. Reset forces IDLE.
- **Accept:** when `in_valid & in_ready & ~flush` in IDLE, latch `op`, `srca` and `srcb`. Multiplies go to MUL; divides go to DIV.
- **Multiply:**
  - Full 2·WIDTH-bit product. MULT is signed × signed; MULTU is unsigned.
  - A cycle counter counts `MUL_CYCLES` cycles, during which the product may be pipelined or registered. The unit then goes to DONE with `{hi,lo}` equal to the product.
- **Divide:**
  - Operands are converted to magnitudes: signed only for DIV, unchanged for DIVU.
  - Restoring algorithm, one quotient bit per cycle, MSB first, for `WIDTH` iteration cycles. A partial remainder of WIDTH+1 bits is shifted in and the divisor is trial-subtracted each cycle.
  - One fix-up cycle follows, after which the unit goes to DONE.
  - DIV sign rules: the quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - `lo` = quotient, `hi` = remainder.
- **Divide special cases** (timing is unchanged in every case):
  - Divisor 0: `lo` = all ones, `hi` = `srca`.
  - DIV of the most-negative value by −1: `lo` = most-negative value, `hi` = 0. This falls out of the magnitude path; no special logic is needed.
- **DONE:**
  - `out_valid`=1; `hi` and `lo` are held stable.
  - On `out_ready` the unit goes to IDLE; `out_valid` drops the next cycle.
- **Flush:**
  - In any state, `flush` returns the unit to IDLE on the next edge, drops `out_valid`, and discards the result.
  - `flush` in the same cycle as `in_valid` in IDLE means nothing is accepted.
  - `flush` together with `out_ready` in DONE goes to IDLE; the result is treated as discarded.
- **No overlap:** `in_ready`=0 outside IDLE. A new operation can be accepted in the cycle after DONE is left, not in the same cycle.
- **Hold:** `hi` and `lo` keep their last value outside DONE. A flush does not clear them.

## Timing
- **Reset values:**
  - `state`=IDLE, `out_valid`=0, `busy`=0, `hi`=0, `lo`=0, all counters 0.
  - `in_ready`=1 while reset is asserted and after it is released.
- **Reset mid-operation:** asynchronous return to the reset values, with no result emitted.
- **Multiply latency:** accepted at cycle edge t, `out_valid` first high at t+`MUL_CYCLES`.
- **Divide latency:** accepted at t, `out_valid` first high at t+`WIDTH`+1, which is 33 for the default width.
- **Back-pressure:** with `out_ready` held 0, the unit stays in DONE indefinitely, with `out_valid`, `hi` and `lo` constant.
- **Throughput, multiply:** with `out_ready`=1 continuously, `MUL_CYCLES`+2 cycles per operation (the accept cycle is not overlapped with DONE).
- **Throughput, divide:** with `out_ready`=1 continuously, `WIDTH`+3 cycles per operation.
- **Outputs:** all outputs are registered, except `in_ready` and `busy`, which decode `state` directly.

## Test plan
- **MULT signed:** MULT `srca`=0xFFFFFFFE (−2), `srcb`=0x00000003 → after 2 cycles `out_valid`; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- **MULT vs MULTU:** MULTU on the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- **DIV signed, negative dividend:** DIV −7 (0xFFFFFFF9) / 2 → `out_valid` 33 cycles after acceptance; `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- **DIVU:** 0xFFFFFFF9 / 2 → `lo`=0x7FFFFFFC, `hi`=1.
- **Divide special cases:**
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5, same latency as a normal divide.
- **Flush and back-pressure:**
  - Flush asserted at iteration 10 of a DIV → IDLE next cycle, `out_valid` never rises, `in_ready`=1.
  - Next, a MULTU 3×4 is accepted and `out_ready` is held low for 5 cycles → `out_valid` stays high with `lo`=12, `hi`=0 throughout; `out_ready` pulse → IDLE.
  - Asynchronous `resetn` pulse mid-MUL → all outputs return to their reset values immediately.
